// File: rtl/dcache_responder_pkg.sv
// Shared types and helpers for the data-cache responder: FSM states,
// request size encodings and the big-endian byte-lane decoder.
package dcache_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_DBL  = 2'b11;

    // Bit 3 enables bits [31:24] (byte offset 0), bit 0 enables bits [7:0].
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: lane_mask = 4'b1000 >> off;
            SZ_HALF: lane_mask = off[1] ? 4'b0011 : 4'b1100;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/dcache_responder_mem.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// The read register returns to zero on any cycle without a read.
module dcache_responder_mem #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_re,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    // NOTE: the storage array has no reset; only the read register is reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_we && i_be[b]) begin
                r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end else begin
            r_rdata <= '0;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dcache_responder.sv
// Data-cache responder for the LEON IU: answers dcache requests with
// registered hold/mds/mexc/werr handshakes and a configurable wait count.
module dcache_responder
    import dcache_responder_pkg::*;
#(
    parameter int          DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
    parameter int          WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_read,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] resp_data,
    output logic        resp_hold,
    output logic        resp_mds,
    output logic        resp_mexc,
    output logic        resp_werr
);

    localparam int         AW       = $clog2(DEPTH);
    localparam bit         HAS_WAIT = (WAIT_STATES > 0);
    localparam logic [3:0] WS_INIT  = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t        r_state;
    logic [3:0]    r_cnt;
    logic [AW-1:0] r_idx;
    logic [1:0]    r_off;
    logic [1:0]    r_size;
    logic          r_read;
    logic [31:0]   r_wdata;
    logic          r_err;
    logic          r_hold;
    logic          r_mds;
    logic          r_mexc;
    logic          r_werr;

    logic          w_in_range;
    logic          w_misalign;
    logic          w_err;
    logic          w_rd_now;
    logic          w_mem_we;
    logic [AW-1:0] w_mem_addr;
    logic [31:0]   w_mem_wdata;

    // BASE_ADDR is DEPTH*4 aligned, so the range test is a tag compare and
    // the word index is simply the address bits above the byte offset.
    assign w_in_range = (req_addr[31:AW+2] == BASE_ADDR[31:AW+2]);

    always_comb begin
        w_misalign = 1'b0;
        case (req_size)
            SZ_HALF:         w_misalign = req_addr[0];
            SZ_WORD, SZ_DBL: w_misalign = |req_addr[1:0];
            default:         w_misalign = 1'b0;
        endcase
    end

    assign w_err = !w_in_range || w_misalign;

    // The RAM read is issued one cycle before RESP so its registered output lines up.
    assign w_rd_now = HAS_WAIT
        ? (r_state == ST_WAIT && r_cnt == 4'd0 && r_read && !r_err)
        : (r_state == ST_IDLE && req_valid && req_read && !w_err);

    assign w_mem_we   = (r_state == ST_RESP) && !r_read && !r_err;
    assign w_mem_addr = (w_mem_we || HAS_WAIT) ? r_idx : req_addr[AW+1:2];

    always_comb begin
        w_mem_wdata = r_wdata;
        case (r_size)
            SZ_BYTE: w_mem_wdata = {4{r_wdata[7:0]}};
            SZ_HALF: w_mem_wdata = {2{r_wdata[15:0]}};
            default: w_mem_wdata = r_wdata;
        endcase
    end

    dcache_responder_mem #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_mem (
        .clk    (clk),
        .rst    (rst),
        .i_re   (w_rd_now),
        .i_we   (w_mem_we),
        .i_be   (lane_mask(r_size, r_off)),
        .i_addr (w_mem_addr),
        .i_wdata(w_mem_wdata),
        .o_rdata(resp_data)
    );

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_off   <= 2'b00;
            r_size  <= SZ_WORD;
            r_read  <= 1'b0;
            r_wdata <= '0;
            r_err   <= 1'b0;
            r_hold  <= 1'b1;
            r_mds   <= 1'b1;
            r_mexc  <= 1'b0;
            r_werr  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_hold <= 1'b1;
                    r_mds  <= 1'b1;
                    r_mexc <= 1'b0;
                    r_werr <= 1'b0;
                    if (req_valid) begin
                        r_idx   <= req_addr[AW+1:2];
                        r_off   <= req_addr[1:0];
                        r_size  <= req_size;
                        r_read  <= req_read;
                        r_wdata <= req_wdata;
                        r_err   <= w_err;
                        if (HAS_WAIT) begin
                            r_state <= ST_WAIT;
                            r_cnt   <= WS_INIT;
                            r_hold  <= 1'b0;
                        end else begin
                            r_state <= ST_RESP;
                            r_mds   <= !req_read;
                            r_mexc  <= req_read && w_err;
                            r_werr  <= !req_read && w_err;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_RESP;
                        r_hold  <= 1'b1;
                        r_mds   <= !r_read;
                        r_mexc  <= r_read && r_err;
                        r_werr  <= !r_read && r_err;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                    r_hold  <= 1'b1;
                    r_mds   <= 1'b1;
                    r_mexc  <= 1'b0;
                    r_werr  <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign resp_hold = r_hold;
    assign resp_mds  = r_mds;
    assign resp_mexc = r_mexc;
    assign resp_werr = r_werr;

endmodule

// File: tb/tb_dcache_responder.sv
// Self-checking bench: three responders (2, 0 and 3 wait states) driven by
// directed vectors, hand-written corner sequences and randomized accesses.
module tb_dcache_responder;

    localparam logic [31:0] BASE  = 32'h4000_0000;
    localparam int          DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst_c = 1'b1;
    logic [2:0]  valid_v = 3'b000;
    logic        req_read = 1'b0;
    logic [1:0]  req_size = 2'b10;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;

    logic [2:0]  hold_v, mds_v, mexc_v, werr_v;
    logic [31:0] data_v [3];

    int ws_of [3] = '{2, 0, 3};
    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] mem_m [3][DEPTH];

    always #5 clk = ~clk;

    dcache_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(2)) dut_a (
        .clk(clk), .rst(rst_n), .req_valid(valid_v[0]), .req_read(req_read),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_data(data_v[0]), .resp_hold(hold_v[0]), .resp_mds(mds_v[0]),
        .resp_mexc(mexc_v[0]), .resp_werr(werr_v[0]));

    dcache_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0)) dut_b (
        .clk(clk), .rst(rst_n), .req_valid(valid_v[1]), .req_read(req_read),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_data(data_v[1]), .resp_hold(hold_v[1]), .resp_mds(mds_v[1]),
        .resp_mexc(mexc_v[1]), .resp_werr(werr_v[1]));

    dcache_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(3)) dut_c (
        .clk(clk), .rst(rst_n && rst_c), .req_valid(valid_v[2]), .req_read(req_read),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_data(data_v[2]), .resp_hold(hold_v[2]), .resp_mds(mds_v[2]),
        .resp_mexc(mexc_v[2]), .resp_werr(werr_v[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: byte-addressed view of each responder's memory.
    task automatic model_apply(input int d, input bit rd, input logic [1:0] sz,
                               input logic [31:0] addr, input logic [31:0] wd,
                               output logic [31:0] ed, output bit em, output bit ew);
        longint a = longint'(addr);
        longint lo = longint'(BASE);
        bit oor = (a < lo) || (a >= lo + DEPTH * 4);
        int off = int'(addr % 4);
        bit mis = (sz == 2'b01) ? (addr % 2 != 0) : (sz[1] ? (off != 0) : 1'b0);
        bit err = oor || mis;
        int idx = oor ? 0 : int'((a - lo) / 4);
        logic [31:0] w;
        ed = '0;
        em = rd && err;
        ew = !rd && err;
        if (rd) begin
            if (!err) ed = mem_m[d][idx];
        end else if (!err) begin
            w = mem_m[d][idx];
            for (int k = 0; k < 4; k++) begin
                if (sz == 2'b00 && k == off)               w[31-8*k -: 8] = wd[7:0];
                else if (sz == 2'b01 && k == off)          w[31-8*k -: 8] = wd[15:8];
                else if (sz == 2'b01 && k == off + 1)      w[31-8*k -: 8] = wd[7:0];
                else if (sz[1])                            w[31-8*k -: 8] = wd[31-8*k -: 8];
            end
            mem_m[d][idx] = w;
        end
    endtask

    // One access: idle check, request, WAIT cycles, RESP cycle. Returns in RESP,
    // so a following call issues in the IDLE cycle right after RESP.
    task automatic access(input int d, input bit rd, input logic [1:0] sz,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_data, input bit exp_mexc,
                          input bit exp_werr, input bit keep_valid, input string tag);
        @(negedge clk);
        check({tag, " idle hold"}, 32'(hold_v[d]), 32'd1);
        check({tag, " idle mds"}, 32'(mds_v[d]), 32'd1);
        req_read = rd;
        req_size = sz;
        req_addr = addr;
        req_wdata = wd;
        valid_v[d] = 1'b1;
        for (int c = 0; c < ws_of[d]; c++) begin
            @(negedge clk);
            if (!keep_valid) valid_v[d] = 1'b0;
            check({tag, " wait hold"}, 32'(hold_v[d]), 32'd0);
            check({tag, " wait mds"}, 32'(mds_v[d]), 32'd1);
        end
        @(negedge clk);
        valid_v[d] = 1'b0;
        check({tag, " resp hold"}, 32'(hold_v[d]), 32'd1);
        check({tag, " resp mds"}, 32'(mds_v[d]), rd ? 32'd0 : 32'd1);
        check({tag, " resp werr"}, 32'(werr_v[d]), 32'(exp_werr));
        if (rd) begin
            check({tag, " resp data"}, data_v[d], exp_data);
            check({tag, " resp mexc"}, 32'(mexc_v[d]), 32'(exp_mexc));
        end
    endtask

    task automatic model_access(input int d, input bit rd, input logic [1:0] sz,
                                input logic [31:0] addr, input logic [31:0] wd,
                                input bit keep_valid, input string tag);
        logic [31:0] ed;
        bit em, ew;
        model_apply(d, rd, sz, addr, wd, ed, em, ew);
        access(d, rd, sz, addr, wd, ed, em, ew, keep_valid, tag);
    endtask

    typedef struct {
        bit          rd;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_data;
        bit          exp_mexc;
        bit          exp_werr;
    } vec_t;

    vec_t vecs [18];

    initial begin
        logic [31:0] ed;
        bit em, ew;

        vecs[0]  = '{1'b0, 2'b10, 32'h4000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0, 1'b0};
        vecs[1]  = '{1'b1, 2'b10, 32'h4000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 2'b10, 32'h4000_0020, 32'h1122_3344, 32'h0,         1'b0, 1'b0};
        vecs[3]  = '{1'b0, 2'b00, 32'h4000_0021, 32'hFFFF_FFAA, 32'h0,         1'b0, 1'b0};
        vecs[4]  = '{1'b0, 2'b01, 32'h4000_0022, 32'h1234_BEEF, 32'h0,         1'b0, 1'b0};
        vecs[5]  = '{1'b1, 2'b10, 32'h4000_0020, 32'h0,         32'h11AA_BEEF, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 2'b10, 32'h4000_0000, 32'hCAFE_F00D, 32'h0,         1'b0, 1'b0};
        vecs[7]  = '{1'b1, 2'b10, 32'h3FFF_FFFC, 32'h0,         32'h0,         1'b1, 1'b0};
        vecs[8]  = '{1'b0, 2'b10, 32'h4000_0002, 32'h1234_5678, 32'h0,         1'b0, 1'b1};
        vecs[9]  = '{1'b1, 2'b10, 32'h4000_0000, 32'h0,         32'hCAFE_F00D, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 2'b10, 32'h4000_0FFC, 32'hA5A5_0001, 32'h0,         1'b0, 1'b0};
        vecs[11] = '{1'b1, 2'b10, 32'h4000_0FFC, 32'h0,         32'hA5A5_0001, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 2'b10, 32'h4000_1000, 32'h0,         32'h0,         1'b1, 1'b0};
        vecs[13] = '{1'b1, 2'b01, 32'h4000_0011, 32'h0,         32'h0,         1'b1, 1'b0};
        vecs[14] = '{1'b1, 2'b00, 32'h4000_0013, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 2'b11, 32'h4000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 2'b01, 32'h4000_0021, 32'h0000_5555, 32'h0,         1'b0, 1'b1};
        vecs[17] = '{1'b1, 2'b10, 32'h4000_0020, 32'h0,         32'h11AA_BEEF, 1'b0, 1'b0};

        // Reset values on every instance.
        #12;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset data %0d", d), data_v[d], 32'h0);
            check($sformatf("reset hold %0d", d), 32'(hold_v[d]), 32'd1);
            check($sformatf("reset mds %0d", d), 32'(mds_v[d]), 32'd1);
            check($sformatf("reset mexc %0d", d), 32'(mexc_v[d]), 32'd0);
            check($sformatf("reset werr %0d", d), 32'(werr_v[d]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors on the 2-wait-state instance; stores also feed the model.
        for (int i = 0; i < 18; i++) begin
            model_apply(0, vecs[i].rd, vecs[i].sz, vecs[i].addr, vecs[i].wd, ed, em, ew);
            access(0, vecs[i].rd, vecs[i].sz, vecs[i].addr, vecs[i].wd,
                   vecs[i].exp_data, vecs[i].exp_mexc, vecs[i].exp_werr, 1'b0,
                   $sformatf("vec%0d", i));
        end

        // req_valid held high through WAIT: only one access may complete.
        model_access(0, 1'b1, 2'b10, 32'h4000_0010, 32'h0, 1'b1, "ignored");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("ignored after hold", 32'(hold_v[0]), 32'd1);
            check("ignored after mds", 32'(mds_v[0]), 32'd1);
        end

        // Zero wait states: preload then four back-to-back loads.
        for (int i = 0; i < 16; i++)
            model_access(1, 1'b0, 2'b10, BASE + 32'(4 * i), $urandom, 1'b0, "b preload");
        for (int i = 0; i < 4; i++)
            model_access(1, 1'b1, 2'b10, BASE + 32'(4 * i), 32'h0, 1'b0, $sformatf("b2b%0d", i));

        // Reset during the second WAIT cycle of a store (3 wait states).
        model_access(2, 1'b0, 2'b10, 32'h4000_0040, 32'hFEED_FACE, 1'b0, "c prior");
        @(negedge clk);
        req_read = 1'b0;
        req_size = 2'b10;
        req_addr = 32'h4000_0040;
        req_wdata = 32'h1234_5678;
        valid_v[2] = 1'b1;
        @(negedge clk);
        valid_v[2] = 1'b0;
        check("c wait1 hold", 32'(hold_v[2]), 32'd0);
        @(posedge clk);
        #1;
        check("c wait2 hold", 32'(hold_v[2]), 32'd0);
        #1;
        rst_c = 1'b0;
        #1;
        check("c abort hold", 32'(hold_v[2]), 32'd1);
        check("c abort mds", 32'(mds_v[2]), 32'd1);
        check("c abort mexc", 32'(mexc_v[2]), 32'd0);
        check("c abort werr", 32'(werr_v[2]), 32'd0);
        check("c abort data", data_v[2], 32'h0);
        repeat (2) @(negedge clk);
        rst_c = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("c post werr", 32'(werr_v[2]), 32'd0);
            check("c post mds", 32'(mds_v[2]), 32'd1);
        end
        model_access(2, 1'b1, 2'b10, 32'h4000_0040, 32'h0, 1'b0, "c reload");

        // Randomized traffic against the model on the waited and zero-wait instances.
        for (int i = 0; i < 16; i++)
            model_access(0, 1'b0, 2'b10, BASE + 32'(4 * i), $urandom, 1'b0, "a preload");
        for (int i = 0; i < 120; i++) begin
            int d = (i % 3 == 0) ? 1 : 0;
            bit rd = 1'($urandom);
            logic [1:0] sz = 2'($urandom);
            logic [31:0] addr;
            if ($urandom_range(0, 7) == 0)
                addr = ($urandom_range(0, 1) == 0) ? BASE - 32'(4 * $urandom_range(1, 4))
                                                   : BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 15));
            else
                addr = BASE + 32'($urandom_range(0, 63));
            model_access(d, rd, sz, addr, $urandom, 1'($urandom), $sformatf("rand%0d", i));
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_responder.md
# dcache_responder

Synthesizable data-cache responder that answers the LEON integer unit's data-cache request bus with the `hold`/`mds`/`mexc`/`werr` handshake the core expects. It replaces the function-call cache stub in self-checking regressions, so load/store sequences run with real multi-cycle wait states. It sits between `iu0` and a local word-addressed memory, which is behind a single internal port.

## Interface
Parameters:
- `DEPTH`, 1024: memory size in 32-bit words; must be a power of two.
- `BASE_ADDR`, 32'h4000_0000: byte address of word 0; must be aligned to `DEPTH*4`.
- `WAIT_STATES`, 2: number of hold cycles inserted per access, 0–15.

Ports:
- `clk`, in, 1: single clock; all logic on its rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, 1: request strobe from `dcache_in_type` (`enaddr`).
- `req_read`, in, 1: 1 = load, 0 = store.
- `req_size`, in, 2: 00 byte, 01 half, 10 word, 11 double (treated as word).
- `req_addr`, in, 32: byte address (`maddress`).
- `req_wdata`, in, 32: store data (`edata`), right-justified for byte and half.
- `resp_data`, out, 32: load data (`dcache_out_type.data`), full big-endian word.
- `resp_hold`, out, 1: active-low; 0 stalls the IU.
- `resp_mds`, out, 1: active-low; 0 marks `resp_data` valid this cycle.
- `resp_mexc`, out, 1: memory exception, qualified by `resp_mds` = 0.
- `resp_werr`, out, 1: store error, one-cycle pulse.

## Operation
- The FSM has three states: IDLE, WAIT and RESP. Reset enters IDLE.
- **IDLE:** `resp_hold`=1 and `resp_mds`=1. When `req_valid`=1, the block latches addr, size, read and wdata, and decodes errors.
  - If `WAIT_STATES`>0, go to WAIT and load the counter with `WAIT_STATES`-1.
  - Otherwise go to RESP.
- **WAIT:** `resp_hold`=0. The counter decrements each cycle, and the FSM goes to RESP when the counter is 0.
- **RESP:** `resp_hold`=1 for one cycle, then return to IDLE.
  - Load: `resp_mds`=0, and `resp_data` = mem[word index].
  - Store: memory is updated at the end of this cycle, and `resp_mds` stays 1.
- `req_valid` outside IDLE is ignored. There is no queueing; the IU does not issue while held.
- Word index is (`req_addr`-`BASE_ADDR`)[log2(DEPTH)+1:2].
- **Errors:**
  - Out of range: `req_addr` < `BASE_ADDR` or ≥ `BASE_ADDR`+`DEPTH*4`.
  - Misaligned: half with addr[0]=1, or word/double with addr[1:0]≠0.
  - On error, a load returns `resp_mexc`=1 with `resp_mds`=0 and `resp_data`=0. A store pulses `resp_werr`=1 in RESP and leaves memory unchanged.
  - Wait states are still applied on error.
- **Store lanes (big-endian):**
  - Byte at offset k writes bits [31-8k -: 8] from `req_wdata[7:0]`.
  - Half at offset 0 writes [31:16] and at offset 2 writes [15:0], from `req_wdata[15:0]`.
  - Word writes all 32 bits.
- **Loads** always return the full word. The IU performs lane selection and extension.

## Timing
- Request sampled at edge T.
- `resp_hold` is 0 for cycles T+1 … T+`WAIT_STATES`.
- RESP occupies cycle T+`WAIT_STATES`+1. Load data is valid there, and store data is visible to a load issued at or after T+`WAIT_STATES`+2.
- With `WAIT_STATES`=0, `resp_hold` never drops and latency is 1 cycle.
- Back-to-back: a request accepted in the IDLE cycle immediately following RESP gives throughput of 1 access per `WAIT_STATES`+2 cycles.
- Reset values: `resp_data`=0, `resp_hold`=1, `resp_mds`=1, `resp_mexc`=0, `resp_werr`=0, state IDLE, counter 0.
- Memory contents are not reset.
- Reset asserted mid-access aborts immediately. A pending store is not committed, and no `resp_mds` or `resp_werr` pulse is produced.
- All outputs are registered; there is no combinational path from `req_*` to `resp_*`.

## Structure
- `dcache_responder_pkg` holds:
  - the state enum (IDLE/WAIT/RESP);
  - size constants SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DBL;
  - the function `lane_mask(size, addr[1:0])` returning a 4-bit big-endian byte enable.
- One sub-module, `dcache_responder_mem`, is natural: a single-port synchronous RAM with `DEPTH` words, 4-bit byte write enable and registered read. The top reads it in the last WAIT cycle, or in the accept cycle when `WAIT_STATES`=0.

## Test plan
- **Word store then load:** store 32'hDEADBEEF to 0x4000_0010, then load 0x4000_0010. Required response: `resp_hold` low 2 cycles on each access; load gives `resp_mds`=0 with `resp_data`=32'hDEADBEEF.
- **Byte and half lanes:** preload word 0x4000_0020 with 32'h11223344. Store byte 8'hAA to 0x4000_0021, then store half 16'hBEEF to 0x4000_0022. Load 0x4000_0020 returns 32'h11AABEEF.
- **Errors:**
  - Load 0x3FFF_FFFC returns `resp_mexc`=1, `resp_mds`=0, `resp_data`=0.
  - Store word to 0x4000_0002 pulses `resp_werr`=1, and a subsequent load of 0x4000_0000 is unchanged.
- **Zero wait states:** with `WAIT_STATES`=0, run 4 back-to-back loads. `resp_hold` stays 1 throughout, and each `resp_mds` pulse occurs 1 cycle after its request.
- **Reset mid-store:** with `WAIT_STATES`=3, assert `rst`=0 during the second WAIT cycle of a store of 32'h12345678 to 0x4000_0040. Required response:
  - outputs go to reset values asynchronously;
  - no `resp_werr` pulse;
  - after release, a load of 0x4000_0040 returns the prior contents.
- **Ignored requests:** drive `req_valid`=1 continuously during WAIT. Exactly one access completes per accepted request, and the state returns to IDLE after RESP.
